// File: rtl/gpu_pkg.sv
// Shared core definitions: core FSM state encodings, special register indices
// and write-back source codes used by the per-lane register file.
package gpu_pkg;

  localparam int DATA_BITS_DEFAULT = 8;
  localparam int NUM_REGS          = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_FETCH   = 3'b001,
    ST_DECODE  = 3'b010,
    ST_REQUEST = 3'b011,
    ST_WAIT    = 3'b100,
    ST_EXECUTE = 3'b101,
    ST_UPDATE  = 3'b110,
    ST_DONE    = 3'b111
  } core_state_t;

  localparam logic [3:0] REG_BLOCK_ID  = 4'd13;
  localparam logic [3:0] REG_BLOCK_DIM = 4'd14;
  localparam logic [3:0] REG_THREAD_ID = 4'd15;

  typedef enum logic [1:0] {
    MUX_ALU = 2'b00,
    MUX_LSU = 2'b01,
    MUX_IMM = 2'b10,
    MUX_RSV = 2'b11
  } reg_mux_t;

  // General-purpose registers occupy every index below the block id slot.
  function automatic logic is_gp_reg(input logic [3:0] addr);
    return addr < REG_BLOCK_ID;
  endfunction

endpackage

// File: rtl/thread_register_file.sv
// Per-lane register file: R0-R12 general purpose, R13 block id (mirrored
// every enabled cycle), R14 block dim and R15 thread id (reset constants).
module thread_register_file
  import gpu_pkg::*;
#(
  parameter int THREAD_ID         = 0,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int DATA_BITS         = DATA_BITS_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           rd_addr,
  input  logic [3:0]           rs_addr,
  input  logic [3:0]           rt_addr,
  input  logic                 reg_write_enable,
  input  logic [1:0]           reg_input_mux,
  input  logic [DATA_BITS-1:0] decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  output logic [DATA_BITS-1:0] rs_data,
  output logic [DATA_BITS-1:0] rt_data
);

  logic [DATA_BITS-1:0] regs_q [NUM_REGS];
  logic [DATA_BITS-1:0] regs_d [NUM_REGS];
  logic [DATA_BITS-1:0] rs_data_q, rs_data_d;
  logic [DATA_BITS-1:0] rt_data_q, rt_data_d;

  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_src_valid;
  logic                 wr_fire;

  always_comb begin
    wr_data      = '0;
    wr_src_valid = 1'b1;
    case (reg_input_mux)
      MUX_ALU: wr_data = alu_out;
      MUX_LSU: wr_data = lsu_out;
      MUX_IMM: wr_data = decoded_immediate;
      default: wr_src_valid = 1'b0;
    endcase
  end

  // Special registers are never write targets; such requests drop silently.
  assign wr_fire = enable && (core_state == ST_UPDATE) && reg_write_enable
                   && wr_src_valid && is_gp_reg(rd_addr);

  always_comb begin
    regs_d    = regs_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    if (enable) begin
      regs_d[REG_BLOCK_ID] = block_id;
      if (core_state == ST_REQUEST) begin
        rs_data_d = regs_q[rs_addr];
        rt_data_d = regs_q[rt_addr];
      end
      if (wr_fire) begin
        regs_d[rd_addr] = wr_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[REG_BLOCK_DIM] <= DATA_BITS'(THREADS_PER_BLOCK);
      regs_q[REG_THREAD_ID] <= DATA_BITS'(THREAD_ID);
      rs_data_q             <= '0;
      rt_data_q             <= '0;
    end else begin
      regs_q    <= regs_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
    end
  end

  assign rs_data = rs_data_q;
  assign rt_data = rt_data_q;

endmodule

// File: tb/tb_thread_register_file.sv
// Directed scenarios followed by randomized traffic, all checked against an
// array-based model of the register file behaviour.
module tb_thread_register_file;

  localparam int TID = 2;
  localparam int TPB = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] block_id;
  logic [2:0] core_state;
  logic [3:0] rd_addr, rs_addr, rt_addr;
  logic       reg_write_enable;
  logic [1:0] reg_input_mux;
  logic [7:0] decoded_immediate, alu_out, lsu_out;
  logic [7:0] rs_data, rt_data;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_regs [16];
  logic [7:0] m_rs, m_rt;

  thread_register_file #(
    .THREAD_ID(TID),
    .THREADS_PER_BLOCK(TPB),
    .DATA_BITS(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .block_id(block_id),
    .core_state(core_state),
    .rd_addr(rd_addr),
    .rs_addr(rs_addr),
    .rt_addr(rt_addr),
    .reg_write_enable(reg_write_enable),
    .reg_input_mux(reg_input_mux),
    .decoded_immediate(decoded_immediate),
    .alu_out(alu_out),
    .lsu_out(lsu_out),
    .rs_data(rs_data),
    .rt_data(rt_data)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: outputs capture pre-edge register values; state 3 = REQUEST, 6 = UPDATE.
  task automatic model_tick();
    logic [7:0] nxt [16];
    nxt = m_regs;
    if (reset) begin
      for (int i = 0; i < 16; i++) nxt[i] = 8'd0;
      nxt[14] = 8'(TPB);
      nxt[15] = 8'(TID);
      m_rs = 8'd0;
      m_rt = 8'd0;
    end else if (enable) begin
      if (core_state == 3'd3) begin
        m_rs = m_regs[rs_addr];
        m_rt = m_regs[rt_addr];
      end
      if (core_state == 3'd6 && reg_write_enable && rd_addr < 4'd13) begin
        if (reg_input_mux == 2'd0) nxt[rd_addr] = alu_out;
        else if (reg_input_mux == 2'd1) nxt[rd_addr] = lsu_out;
        else if (reg_input_mux == 2'd2) nxt[rd_addr] = decoded_immediate;
      end
      nxt[13] = block_id;
    end
    m_regs = nxt;
  endtask

  task automatic cycle();
    model_tick();
    @(posedge clock);
    #1;
    check_eq("model_rs", rs_data, m_rs);
    check_eq("model_rt", rt_data, m_rt);
  endtask

  task automatic do_update(input logic [3:0] rd, input logic [1:0] mux,
                           input logic [7:0] alu, input logic [7:0] lsu, input logic [7:0] imm);
    core_state        = 3'd6;
    reg_write_enable  = 1'b1;
    rd_addr           = rd;
    reg_input_mux     = mux;
    alu_out           = alu;
    lsu_out           = lsu;
    decoded_immediate = imm;
    cycle();
    reg_write_enable  = 1'b0;
    core_state        = 3'd7;
  endtask

  task automatic do_read(input string tag, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [7:0] exp_rs, input logic [7:0] exp_rt);
    core_state = 3'd3;
    rs_addr    = rs;
    rt_addr    = rt;
    cycle();
    core_state = 3'd4;
    check_eq({tag, "_rs"}, rs_data, exp_rs);
    check_eq({tag, "_rt"}, rt_data, exp_rt);
    cycle();
    check_eq({tag, "_hold"}, rs_data, exp_rs);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; block_id = 8'd0; core_state = 3'd0;
    rd_addr = '0; rs_addr = '0; rt_addr = '0; reg_write_enable = 1'b0;
    reg_input_mux = 2'd0; decoded_immediate = '0; alu_out = '0; lsu_out = '0;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'hxx;
    m_rs = 8'hxx; m_rt = 8'hxx;

    cycle();
    cycle();
    check_eq("reset_rs", rs_data, 8'h00);
    check_eq("reset_rt", rt_data, 8'h00);
    reset = 1'b0;

    // Specials and zeroed GP registers after reset
    do_read("special", 4'd14, 4'd15, 8'd4, 8'd2);
    for (int i = 0; i < 13; i++) do_read("gp_zero", 4'(i), 4'(12 - i), 8'd0, 8'd0);

    do_update(4'd3, 2'd0, 8'h5A, 8'h00, 8'h00);
    do_read("alu_wb", 4'd3, 4'd3, 8'h5A, 8'h5A);

    do_update(4'd15, 2'd2, 8'h00, 8'h00, 8'hFF);
    do_read("r15_ro", 4'd15, 4'd14, 8'd2, 8'd4);

    do_update(4'd4, 2'd3, 8'h77, 8'h77, 8'h77);
    do_read("mux_rsv", 4'd4, 4'd3, 8'h00, 8'h5A);
    do_update(4'd4, 2'd1, 8'h00, 8'h81, 8'h00);
    do_read("lsu_wb", 4'd4, 4'd4, 8'h81, 8'h81);

    // Lane disabled: reads, writes and the block id mirror all freeze
    do_read("pre_dis", 4'd3, 4'd4, 8'h5A, 8'h81);
    enable   = 1'b0;
    block_id = 8'd7;
    do_read("dis_read", 4'd0, 4'd0, 8'h5A, 8'h81);
    do_update(4'd3, 2'd0, 8'h11, 8'h00, 8'h00);
    enable = 1'b1;
    do_read("dis_wr", 4'd3, 4'd13, 8'h5A, 8'h00);
    do_read("mirror", 4'd13, 4'd3, 8'd7, 8'h5A);

    do_update(4'd5, 2'd0, 8'h22, 8'h00, 8'h00);
    do_read("r5_set", 4'd5, 4'd5, 8'h22, 8'h22);
    reset = 1'b1;
    do_update(4'd5, 2'd0, 8'h33, 8'h00, 8'h00);
    reset = 1'b0;
    check_eq("rst_mid_rs", rs_data, 8'h00);
    check_eq("rst_mid_rt", rt_data, 8'h00);
    do_read("r5_cleared", 4'd5, 4'd13, 8'h00, 8'h00);

    for (int n = 0; n < 3000; n++) begin
      reset             = ($urandom_range(0, 127) == 0);
      enable            = ($urandom_range(0, 3) != 0);
      block_id          = 8'($urandom);
      core_state        = 3'($urandom);
      rd_addr           = 4'($urandom);
      rs_addr           = 4'($urandom);
      rt_addr           = ($urandom_range(0, 7) == 0) ? rs_addr : 4'($urandom);
      reg_write_enable  = ($urandom_range(0, 3) != 0);
      reg_input_mux     = 2'($urandom);
      decoded_immediate = 8'($urandom);
      alu_out           = 8'($urandom);
      lsu_out           = 8'($urandom);
      cycle();
    end

    // Sweep every register through the read port to compare full contents
    reset = 1'b0; enable = 1'b1; reg_write_enable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      core_state = 3'd3;
      rs_addr    = 4'(i);
      rt_addr    = 4'(15 - i);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
